dpram_mailbox_ctrl: RTL and testbench



---
 rtl/dpram_mailbox_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dpram_mailbox_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_mailbox_ctrl.sv
// Round-robin mailbox controller: pulls operands for a channel from the shared RAM,
// runs the accelerator, and writes back the result and status words.
module dpram_mailbox_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned N_OPS       = 2,
  parameter int unsigned CH_STRIDE   = 8,
  parameter int unsigned OP_OFS      = 2,
  parameter int unsigned RES_OFS     = 6,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic [ADDR_W-1:0]       ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_W-1:0]       ram_wdata_o,
  input  logic [DATA_W-1:0]       ram_rdata_i,
  output logic [N_OPS*DATA_W-1:0] acc_ops_o,
  output logic                    acc_start_o,
  output logic                    acc_abort_o,
  input  logic                    acc_done_i,
  input  logic                    acc_err_i,
  input  logic [DATA_W-1:0]       acc_result_i,
  output logic [2:0]              ch_o,
  output logic                    busy_o,
  output logic [N_CH-1:0]         irq_o,
  output logic [3:0]              state_o
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned K_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_POLL_CHK   = 4'd1,
    S_LOAD_RD    = 4'd2,
    S_LOAD_CAP   = 4'd3,
    S_START      = 4'd4,
    S_WAIT_DONE  = 4'd5,
    S_WR_RES     = 4'd6,
    S_WR_STATUS  = 4'd7,
    S_CLR_STATUS = 4'd8
  } state_e;

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [K_W-1:0]    k_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_CH-1:0]   pend_q;
  logic              err_q;
  logic [ADDR_W-1:0] base_cur;
  logic [ADDR_W-1:0] base_nxt;

  assign ptr_nxt  = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign base_cur = ADDR_W'(32'(ptr_q) * CH_STRIDE);
  assign base_nxt = ADDR_W'(32'(ptr_nxt) * CH_STRIDE);
  assign ch_o     = 3'(ptr_q);
  assign state_o  = 4'(state_q);

  // Outputs are registered against the state being entered, so they line up with that state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_wdata_o <= '0;
      acc_ops_o   <= '0;
      acc_start_o <= 1'b0;
      acc_abort_o <= 1'b0;
      busy_o      <= 1'b0;
      irq_o       <= '0;
    end else begin
      ram_we_o    <= 1'b0;
      acc_start_o <= 1'b0;
      acc_abort_o <= 1'b0;
      irq_o       <= '0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_POLL_CHK;
          busy_o  <= 1'b0;
        end
        S_POLL_CHK: begin
          if (pend_q[ptr_q] && !ram_rdata_i[0]) begin
            state_q     <= S_CLR_STATUS;
            ram_we_o    <= 1'b1;
            ram_addr_o  <= base_cur + ADDR_W'(1);
            ram_wdata_o <= '0;
            busy_o      <= 1'b1;
          end else if (!pend_q[ptr_q] && ram_rdata_i[0]) begin
            state_q    <= S_LOAD_RD;
            k_q        <= '0;
            ram_addr_o <= base_cur + ADDR_W'(OP_OFS);
            busy_o     <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            ptr_q      <= ptr_nxt;
            ram_addr_o <= base_nxt;
            busy_o     <= 1'b0;
          end
        end
        S_LOAD_RD: state_q <= S_LOAD_CAP;
        S_LOAD_CAP: begin
          acc_ops_o[32'(k_q)*DATA_W +: DATA_W] <= ram_rdata_i;
          if (k_q == K_W'(N_OPS - 1)) begin
            state_q     <= S_START;
            acc_start_o <= 1'b1;
          end else begin
            state_q    <= S_LOAD_RD;
            k_q        <= k_q + K_W'(1);
            ram_addr_o <= base_cur + ADDR_W'(OP_OFS) + ADDR_W'(k_q) + ADDR_W'(1);
          end
        end
        S_START: begin
          state_q <= S_WAIT_DONE;
          cnt_q   <= '0;
        end
        // A done seen in the same cycle as the last timeout count takes priority.
        S_WAIT_DONE: begin
          if (acc_done_i) begin
            state_q     <= S_WR_RES;
            err_q       <= acc_err_i;
            ram_we_o    <= 1'b1;
            ram_addr_o  <= base_cur + ADDR_W'(RES_OFS);
            ram_wdata_o <= acc_result_i;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q       <= S_WR_STATUS;
            acc_abort_o   <= 1'b1;
            ram_we_o      <= 1'b1;
            ram_addr_o    <= base_cur + ADDR_W'(1);
            ram_wdata_o   <= DATA_W'(3'b100);
            pend_q[ptr_q] <= 1'b1;
            irq_o[ptr_q]  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WR_RES: begin
          state_q       <= S_WR_STATUS;
          ram_we_o      <= 1'b1;
          ram_addr_o    <= base_cur + ADDR_W'(1);
          ram_wdata_o   <= DATA_W'({1'b0, err_q, 1'b1});
          pend_q[ptr_q] <= 1'b1;
          irq_o[ptr_q]  <= 1'b1;
        end
        S_WR_STATUS: begin
          state_q    <= S_IDLE;
          ptr_q      <= ptr_nxt;
          ram_addr_o <= base_nxt;
          busy_o     <= 1'b0;
        end
        S_CLR_STATUS: begin
          state_q       <= S_IDLE;
          pend_q[ptr_q] <= 1'b0;
          ptr_q         <= ptr_nxt;
          ram_addr_o    <= base_nxt;
          busy_o        <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          ram_addr_o <= base_cur;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_mailbox_ctrl.sv
// Directed bench for dpram_mailbox_ctrl: host-side RAM model plus scripted accelerator responses.
module tb_dpram_mailbox_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  ram_addr_o;
  logic        ram_we_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic [63:0] acc_ops_o;
  logic        acc_start_o;
  logic        acc_abort_o;
  logic        acc_done_i = 1'b0;
  logic        acc_err_i = 1'b0;
  logic [31:0] acc_result_i = '0;
  logic [2:0]  ch_o;
  logic        busy_o;
  logic [1:0]  irq_o;
  logic [3:0]  state_o;

  logic [31:0] mem [256];
  logic        mem_clr = 1'b1;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  dpram_mailbox_ctrl #(
    .ADDR_W(8), .DATA_W(32), .N_CH(2), .N_OPS(2), .CH_STRIDE(8),
    .OP_OFS(2), .RES_OFS(6), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .acc_ops_o(acc_ops_o), .acc_start_o(acc_start_o), .acc_abort_o(acc_abort_o),
    .acc_done_i(acc_done_i), .acc_err_i(acc_err_i), .acc_result_i(acc_result_i),
    .ch_o(ch_o), .busy_o(busy_o), .irq_o(irq_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Dual-port RAM: port A is the host, port B the controller; reads are read-first.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (host_we) mem[host_addr] <= host_wdata;
      if (ram_we_o) begin
        mem[ram_addr_o] <= ram_wdata_o;
        wr_cnt <= wr_cnt + 1;
      end
    end
    ram_rdata_i <= mem[ram_addr_o];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk_i);
    host_we    = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (acc_start_o) break;
      @(negedge clk_i);
    end
    chk(tag, 64'(acc_start_o), 64'd1);
  endtask

  task automatic wait_clear(input string tag, input logic [7:0] a);
    for (int i = 0; i < 60; i++) begin
      if (mem[a] == 32'd0) break;
      @(negedge clk_i);
    end
    chk(tag, 64'(mem[a]), 64'd0);
  endtask

  task automatic pulse_done(input logic [31:0] r, input logic e);
    acc_done_i   = 1'b1;
    acc_result_i = r;
    acc_err_i    = e;
    @(negedge clk_i);
    acc_done_i   = 1'b0;
    acc_err_i    = 1'b0;
  endtask

  initial begin
    int t0;
    int s;
    int n_st;
    int w0;

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_addr", 64'(ram_addr_o), 64'd0);
    chk("rst_outs", 64'({ram_we_o, acc_start_o, acc_abort_o, busy_o, irq_o, ch_o}), 64'd0);
    chk("rst_ops", acc_ops_o, 64'd0);
    mem_clr = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Channel 1 job: operands 5,7 -> result 12
    host_wr(8'd10, 32'd5);
    host_wr(8'd11, 32'd7);
    host_wr(8'd8, 32'd1);
    t0 = -100;
    for (int i = 0; i < 200; i++) begin
      if (acc_start_o) break;
      if (state_o == 4'd1 && ram_rdata_i[0] && ch_o == 3'd1) t0 = cyc;
      @(negedge clk_i);
    end
    chk("j1_start", 64'(acc_start_o), 64'd1);
    chk("j1_start_lat", 64'(cyc - t0), 64'd5);
    chk("j1_ops", acc_ops_o, {32'd7, 32'd5});
    chk("j1_ch", 64'(ch_o), 64'd1);
    chk("j1_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    chk("j1_wait_state", 64'(state_o), 64'd5);
    chk("j1_wait_lat", 64'(cyc - t0), 64'd6);
    pulse_done(32'd12, 1'b0);
    chk("j1_res_wr", 64'({ram_we_o, ram_addr_o, ram_wdata_o}), {23'd0, 1'b1, 8'd14, 32'd12});
    @(negedge clk_i);
    chk("j1_st_wr", 64'({ram_we_o, ram_addr_o, ram_wdata_o}), {23'd0, 1'b1, 8'd9, 32'd1});
    chk("j1_irq", 64'(irq_o), 64'd2);
    @(negedge clk_i);
    chk("j1_irq_off", 64'(irq_o), 64'd0);
    chk("j1_mem_res", 64'(mem[14]), 64'd12);
    chk("j1_mem_st", 64'(mem[9]), 64'd1);

    // START held high: no restart
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      if (acc_start_o) n_st++;
      @(negedge clk_i);
    end
    chk("hold_no_restart", 64'(n_st), 64'd0);
    chk("hold_status", 64'(mem[9]), 64'd1);
    host_wr(8'd8, 32'd0);
    wait_clear("clr_status_ch1", 8'd9);

    // Error job on channel 1
    host_wr(8'd10, 32'd2);
    host_wr(8'd11, 32'd3);
    host_wr(8'd8, 32'd1);
    wait_start("err_start");
    chk("err_ops", acc_ops_o, {32'd3, 32'd2});
    @(negedge clk_i);
    pulse_done(32'd99, 1'b1);
    repeat (2) @(negedge clk_i);
    chk("err_mem_res", 64'(mem[14]), 64'd99);
    chk("err_mem_st", 64'(mem[9]), 64'd3);
    host_wr(8'd8, 32'd0);
    wait_clear("err_clr", 8'd9);

    // Timeout on channel 0
    host_wr(8'd6, 32'hAAAA);
    host_wr(8'd2, 32'd1);
    host_wr(8'd3, 32'd1);
    host_wr(8'd0, 32'd1);
    wait_start("to_start");
    chk("to_ch", 64'(ch_o), 64'd0);
    s = cyc;
    for (int i = 0; i < 40; i++) begin
      if (acc_abort_o) break;
      @(negedge clk_i);
    end
    chk("to_abort", 64'(acc_abort_o), 64'd1);
    chk("to_abort_lat", 64'(cyc - s), 64'd17);
    chk("to_st_wr", 64'({ram_we_o, ram_addr_o, ram_wdata_o}), {23'd0, 1'b1, 8'd1, 32'd4});
    chk("to_irq", 64'(irq_o), 64'd1);
    @(negedge clk_i);
    chk("to_abort_pulse", 64'(acc_abort_o), 64'd0);
    chk("to_mem_st", 64'(mem[1]), 64'd4);
    chk("to_mem_res", 64'(mem[6]), 64'hAAAA);
    host_wr(8'd0, 32'd0);
    wait_clear("to_clr", 8'd1);

    // Reset during WAIT_DONE, then job restarts
    host_wr(8'd10, 32'd21);
    host_wr(8'd11, 32'd22);
    host_wr(8'd8, 32'd1);
    wait_start("rs_start");
    repeat (3) @(negedge clk_i);
    chk("rs_pre_state", 64'(state_o), 64'd5);
    w0 = wr_cnt;
    rst_i = 1'b0;
    #1;
    chk("rs_state", 64'(state_o), 64'd0);
    chk("rs_outs", 64'({ram_we_o, acc_start_o, acc_abort_o, busy_o, irq_o, ch_o, ram_addr_o}), 64'd0);
    chk("rs_ops", acc_ops_o, 64'd0);
    repeat (3) @(negedge clk_i);
    chk("rs_no_write", 64'(wr_cnt - w0), 64'd0);
    rst_i = 1'b1;
    wait_start("rs_restart");
    chk("rs_restart_ch", 64'(ch_o), 64'd1);
    chk("rs_restart_ops", acc_ops_o, {32'd22, 32'd21});
    @(negedge clk_i);
    pulse_done(32'd43, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("rs_mem_res", 64'(mem[14]), 64'd43);
    host_wr(8'd8, 32'd0);
    wait_clear("rs_clr", 8'd9);

    // Both channels armed together: ch0 completes before ch1 starts
    rst_i = 1'b0;
    host_wr(8'd2, 32'd4);
    host_wr(8'd3, 32'd6);
    host_wr(8'd0, 32'd1);
    host_wr(8'd10, 32'd8);
    host_wr(8'd11, 32'd9);
    host_wr(8'd8, 32'd1);
    rst_i = 1'b1;
    for (int j = 0; j < 2; j++) begin
      wait_start($sformatf("both_start%0d", j));
      chk($sformatf("both_ch%0d", j), 64'(ch_o), 64'(j));
      chk($sformatf("both_ops%0d", j), acc_ops_o, (j == 0) ? {32'd6, 32'd4} : {32'd9, 32'd8});
      @(negedge clk_i);
      pulse_done((j == 0) ? 32'd10 : 32'd17, 1'b0);
      for (int i = 0; i < 10; i++) begin
        if (irq_o != 2'b00) break;
        @(negedge clk_i);
      end
      chk($sformatf("both_irq%0d", j), 64'(irq_o), (j == 0) ? 64'd1 : 64'd2);
      @(negedge clk_i);
    end
    chk("both_res0", 64'(mem[6]), 64'd10);
    chk("both_res1", 64'(mem[14]), 64'd17);
    chk("both_st", 64'({mem[1][7:0], mem[9][7:0]}), 64'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
